// File: rtl/axi_pkg.sv
// ============================================================================
// Module      : axi_pkg
// Description : AXI4 widths, field types, burst/response codes and the
//               burst-legality helper. AXI_RAM_WRAP_EN enables WRAP bursts.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [STRB_W-1:0] strb_t;
    typedef logic [7:0]        len_t;
    typedef logic [2:0]        size_t;
    typedef logic [1:0]        burst_t;
    typedef logic [1:0]        resp_t;

    localparam burst_t BURST_FIXED = 2'b00;
    localparam burst_t BURST_INCR  = 2'b01;
    localparam burst_t BURST_WRAP  = 2'b10;
    localparam burst_t BURST_RSVD  = 2'b11;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;

    localparam size_t SIZE_MAX = size_t'($clog2(STRB_W));

    // A burst whose attributes make every beat an error
    function automatic logic burst_cfg_err(input len_t len, input size_t size,
                                           input burst_t burst);
        logic e;
        e = (size > SIZE_MAX) || (burst == BURST_RSVD);
        if (burst == BURST_WRAP) begin
`ifdef AXI_RAM_WRAP_EN
            e = e || !(len inside {8'd1, 8'd3, 8'd7, 8'd15});
`else
            e = 1'b1;
`endif
        end
        return e;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axi_if.sv
// ============================================================================
// Module      : axi_if
// Description : AXI4 bundle (AR, R, AW, W, B) with master and slave modports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface axi_if;
    import axi_pkg::*;

    addr_t  awaddr;
    len_t   awlen;
    size_t  awsize;
    burst_t awburst;
    logic   awvalid;
    logic   awready;

    data_t  wdata;
    strb_t  wstrb;
    logic   wlast;
    logic   wvalid;
    logic   wready;

    resp_t  bresp;
    logic   bvalid;
    logic   bready;

    addr_t  araddr;
    len_t   arlen;
    size_t  arsize;
    burst_t arburst;
    logic   arvalid;
    logic   arready;

    data_t  rdata;
    resp_t  rresp;
    logic   rlast;
    logic   rvalid;
    logic   rready;

    modport master (
        output awaddr, awlen, awsize, awburst, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arlen, arsize, arburst, arvalid, input arready,
        input  rdata, rresp, rlast, rvalid, output rready
    );

    modport slave (
        input  awaddr, awlen, awsize, awburst, awvalid, output awready,
        input  wdata, wstrb, wlast, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arlen, arsize, arburst, arvalid, output arready,
        output rdata, rresp, rlast, rvalid, input rready
    );

endinterface

`default_nettype wire

// File: rtl/axi_burst_addr.sv
// ============================================================================
// Module      : axi_burst_addr
// Description : Combinational next-beat address for FIXED/INCR/WRAP bursts.
//               Wrap-window logic exists only when AXI_RAM_WRAP_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_burst_addr
    import axi_pkg::*;
(
    input  addr_t  i_addr,
    input  len_t   i_len,
    input  size_t  i_size,
    input  burst_t i_burst,
    output addr_t  o_next_addr
);

    addr_t w_step;
    addr_t w_incr;

    // Later INCR beats are aligned to the transfer size
    always_comb begin
        w_step = addr_t'(1) << i_size;
        w_incr = (i_addr & ~(w_step - addr_t'(1))) + w_step;
    end

`ifdef AXI_RAM_WRAP_EN
    addr_t w_win_mask;
    addr_t w_wrap;

    always_comb begin
        w_win_mask = ((addr_t'(i_len) + addr_t'(1)) << i_size) - addr_t'(1);
        w_wrap     = (i_addr & ~w_win_mask) | ((i_addr + w_step) & w_win_mask);
    end
`else
    logic w_unused_len;
    assign w_unused_len = ^i_len;
`endif

    always_comb begin
        o_next_addr = w_incr;
        case (i_burst)
            BURST_FIXED: o_next_addr = i_addr;
`ifdef AXI_RAM_WRAP_EN
            BURST_WRAP:  o_next_addr = w_wrap;
`endif
            default:     o_next_addr = w_incr;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/axi_ram_slave.sv
// ============================================================================
// Module      : axi_ram_slave
// Description : Burst-capable AXI4 RAM slave with independent read and write
//               engines. WRAP bursts are served only with AXI_RAM_WRAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_ram_slave
    import axi_pkg::*;
#(
    parameter int    MEM_DEPTH = 1024,
    parameter addr_t BASE_ADDR = '0
)
(
    input  logic  clk,
    input  logic  rst,
    axi_if.slave  s_axi
);

    localparam int    c_addr_lsb  = $clog2(STRB_W);
    localparam int    c_idx_w     = $clog2(MEM_DEPTH);
    localparam addr_t c_mem_bytes = addr_t'(MEM_DEPTH * STRB_W);

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    data_t r_mem [MEM_DEPTH];

    // ------------------------------------------------------------------ write
    logic [1:0]         r_wstate;
    addr_t              r_waddr;
    len_t               r_wlen;
    size_t              r_wsize;
    burst_t             r_wburst;
    len_t               r_wcnt;
    logic               r_wcfg_err;
    logic               r_werr;
    logic               r_awready;
    logic               r_wready;
    logic               r_bvalid;
    resp_t              r_bresp;

    addr_t              w_wnext;
    addr_t              w_woff;
    logic               w_win_range;
    logic [c_idx_w-1:0] w_widx;
    logic               w_whs;
    logic               w_wlast_beat;
    logic               w_wbeat_err;
    logic               w_we;

    axi_burst_addr u_waddr (
        .i_addr      (r_waddr),
        .i_len       (r_wlen),
        .i_size      (r_wsize),
        .i_burst     (r_wburst),
        .o_next_addr (w_wnext)
    );

    always_comb begin
        w_woff       = r_waddr - BASE_ADDR;
        w_win_range  = w_woff < c_mem_bytes;
        w_widx       = c_idx_w'(w_woff >> c_addr_lsb);
        w_whs        = s_axi.wvalid && r_wready;
        w_wlast_beat = (r_wcnt == r_wlen);
        w_wbeat_err  = r_wcfg_err || !w_win_range || (s_axi.wlast != w_wlast_beat);
        w_we         = w_whs && !r_wcfg_err && w_win_range;
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (s_axi.wstrb[i]) begin
                    r_mem[w_widx][8*i +: 8] <= s_axi.wdata[8*i +: 8];
                end
            end
        end
    end

    // Only one write outstanding: awready stays low from AW until the B handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wstate   <= W_IDLE;
            r_waddr    <= '0;
            r_wlen     <= '0;
            r_wsize    <= '0;
            r_wburst   <= '0;
            r_wcnt     <= '0;
            r_wcfg_err <= 1'b0;
            r_werr     <= 1'b0;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    r_awready <= 1'b1;
                    if (s_axi.awvalid && r_awready) begin
                        r_waddr    <= s_axi.awaddr;
                        r_wlen     <= s_axi.awlen;
                        r_wsize    <= s_axi.awsize;
                        r_wburst   <= s_axi.awburst;
                        r_wcnt     <= '0;
                        r_wcfg_err <= burst_cfg_err(s_axi.awlen, s_axi.awsize, s_axi.awburst);
                        r_werr     <= 1'b0;
                        r_awready  <= 1'b0;
                        r_wready   <= 1'b1;
                        r_wstate   <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_whs) begin
                        r_waddr <= w_wnext;
                        r_wcnt  <= r_wcnt + len_t'(1);
                        r_werr  <= r_werr || w_wbeat_err;
                        if (w_wlast_beat) begin
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_bresp  <= (r_werr || w_wbeat_err) ? RESP_SLVERR : RESP_OKAY;
                            r_wstate <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi.bready) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------- read
    logic [0:0]         r_rstate;
    addr_t              r_raddr;
    len_t               r_rlen;
    size_t              r_rsize;
    burst_t             r_rburst;
    len_t               r_rcnt;
    logic               r_rcfg_err;
    logic               r_arready;
    logic               r_rvalid;
    logic               r_rlast;
    resp_t              r_rresp;
    data_t              r_rdata;

    addr_t              w_rnext;
    logic               w_arhs;
    logic               w_rhs;
    addr_t              w_faddr;
    logic               w_fcfg_err;
    logic               w_flast;
    addr_t              w_foff;
    logic               w_fin_range;
    logic [c_idx_w-1:0] w_fidx;
    logic               w_ferr;
    data_t              w_fdata;

    axi_burst_addr u_raddr (
        .i_addr      (r_raddr),
        .i_len       (r_rlen),
        .i_size      (r_rsize),
        .i_burst     (r_rburst),
        .o_next_addr (w_rnext)
    );

    // Fetch path: the AR request when idle, otherwise the following beat
    always_comb begin
        w_arhs = s_axi.arvalid && r_arready;
        w_rhs  = r_rvalid && s_axi.rready;
        if (r_rstate == R_IDLE) begin
            w_faddr    = s_axi.araddr;
            w_fcfg_err = burst_cfg_err(s_axi.arlen, s_axi.arsize, s_axi.arburst);
            w_flast    = (s_axi.arlen == '0);
        end else begin
            w_faddr    = w_rnext;
            w_fcfg_err = r_rcfg_err;
            w_flast    = ((r_rcnt + len_t'(1)) == r_rlen);
        end
        w_foff      = w_faddr - BASE_ADDR;
        w_fin_range = w_foff < c_mem_bytes;
        w_fidx      = c_idx_w'(w_foff >> c_addr_lsb);
        w_ferr      = w_fcfg_err || !w_fin_range;
        w_fdata     = w_ferr ? '0 : r_mem[w_fidx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rstate   <= R_IDLE;
            r_raddr    <= '0;
            r_rlen     <= '0;
            r_rsize    <= '0;
            r_rburst   <= '0;
            r_rcnt     <= '0;
            r_rcfg_err <= 1'b0;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rlast    <= 1'b0;
            r_rresp    <= RESP_OKAY;
            r_rdata    <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    r_arready <= 1'b1;
                    if (w_arhs) begin
                        r_raddr    <= s_axi.araddr;
                        r_rlen     <= s_axi.arlen;
                        r_rsize    <= s_axi.arsize;
                        r_rburst   <= s_axi.arburst;
                        r_rcnt     <= '0;
                        r_rcfg_err <= w_fcfg_err;
                        r_arready  <= 1'b0;
                        r_rvalid   <= 1'b1;
                        r_rdata    <= w_fdata;
                        r_rresp    <= w_ferr ? RESP_SLVERR : RESP_OKAY;
                        r_rlast    <= w_flast;
                        r_rstate   <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (w_rhs) begin
                        if (r_rlast) begin
                            r_rvalid  <= 1'b0;
                            r_rlast   <= 1'b0;
                            r_arready <= 1'b1;
                            r_rstate  <= R_IDLE;
                        end else begin
                            r_raddr <= w_rnext;
                            r_rcnt  <= r_rcnt + len_t'(1);
                            r_rdata <= w_fdata;
                            r_rresp <= w_ferr ? RESP_SLVERR : RESP_OKAY;
                            r_rlast <= w_flast;
                        end
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign s_axi.awready = r_awready;
    assign s_axi.wready  = r_wready;
    assign s_axi.bvalid  = r_bvalid;
    assign s_axi.bresp   = r_bresp;
    assign s_axi.arready = r_arready;
    assign s_axi.rvalid  = r_rvalid;
    assign s_axi.rlast   = r_rlast;
    assign s_axi.rresp   = r_rresp;
    assign s_axi.rdata   = r_rdata;

endmodule

`default_nettype wire

// File: doc/axi_ram_slave.md
Name: axi_ram_slave

Overview:
- Burst-capable AXI4 memory slave; terminates the slave modport of axi_if and consumes every transaction a master drives onto it.
- Independent read and write engines on a shared byte-addressable word array.
- Serves as the default memory endpoint for master bring-up and system simulation.

Parameters:
MEM_DEPTH, 1024, number of DATA_W-bit words; must be a power of two.
BASE_ADDR, 0, byte address mapped to word 0; must be aligned to MEM_DEPTH*STRB_W.

Ports:
clk  input  1  single clock for all logic.
rst  input  1  asynchronous, active-high reset.
s_axi  modport  axi_if.slave  full AXI4 slave bundle: AR, R, AW, W and B channels; widths come from axi_pkg.

Behaviour:
- Reset (async assert, sync release): arready=0, awready=0, wready=0, rvalid=0, bvalid=0, rlast=0, rresp=OKAY, bresp=OKAY, rdata=0. Both FSMs return to IDLE. Any in-flight burst is abandoned with no response. Memory contents are not reset.
- Write FSM states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: awready=1. On awvalid, latch awaddr, awlen, awsize and awburst; clear the beat counter and err flag; go to W_DATA.
  - W_DATA: wready=1. On each wvalid&&wready, write byte i of the current word when wstrb[i]=1, then advance the address and beat counter. The beat with count==len goes to W_RESP.
  - W_RESP: bvalid=1; bresp=SLVERR if err else OKAY. On bready, go to W_IDLE. awready is deasserted from AW acceptance until the B handshake, so only one write is outstanding.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: arready=1. On AR handshake, latch the request. The first beat appears with rvalid=1 on the next cycle.
  - R_DATA: rdata, rresp and rlast stay stable while rvalid&&!rready. On a handshake, the next beat is presented the following cycle with no bubble. rlast=1 on the beat where count==len. The handshake on the last beat returns to R_IDLE.
- Address advance, using the 1<<size byte step:
  - FIXED: address unchanged.
  - INCR: add the step.
  - WRAP: add the step, wrapping within a window of (len+1)<<size bytes aligned to that window size.
- Error cases (resp=SLVERR):
  - size > log2(STRB_W): whole burst errors; writes suppressed; reads return rdata=0.
  - Word index outside [0, MEM_DEPTH): that beat errors, its write is dropped and read data is 0.
  - wlast mismatch (wlast=1 before beat len, or 0 on beat len): err set; the burst still ends at beat len.
  - WRAP with len not in {1,3,7,15}: whole burst errors.
- Unaligned INCR start address: the first beat uses the unaligned address; later beats are aligned to size. Byte lanes are gated only by wstrb.
- Simultaneous read and write to the same word in the same cycle: the read returns the pre-write value.
- 4 KB boundary crossing is not checked.
- BURST value 2'b11 (reserved): whole burst errors.

Optional Feature:
- Macro AXI_RAM_WRAP_EN.
- Defined: WRAP bursts are supported as described above.
- Undefined: WRAP bursts are accepted but every beat returns SLVERR; no write occurs and read data is 0. The wrap-window logic is not synthesized.

Decomposition:
- axi_pkg (existing) holds the types and constants: addr_t, data_t, strb_t, len_t, size_t, burst_t, resp_t, ADDR_W, DATA_W, STRB_W.
- Add burst constants to axi_pkg: BURST_FIXED=2'b00, BURST_INCR=2'b01, BURST_WRAP=2'b10.
- Add response constants to axi_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
- Sub-module axi_burst_addr: combinational next-address calculation from addr, len, size and burst. Instantiated once per engine.

Test Plan:
- Single write then read: awaddr=0x10, len=0, size=2, INCR, wdata=0xDEADBEEF, wstrb=0xF → bresp=OKAY. Read of 0x10 → rdata=0xDEADBEEF, rlast=1, rresp=OKAY.
- INCR burst with rready toggling 1-0-1: write 8 beats at 0x100 with data 0..7 → read returns 0..7 in order, rdata stable while stalled, rlast only on beat 7.
- Partial strobes: write 0x11223344, then write 0xAABBCCDD with wstrb=0x5 → read returns 0x11BB33DD.
- WRAP with AXI_RAM_WRAP_EN defined: len=3, size=2, start 0x38 → beats land at 0x38, 0x3C, 0x30, 0x34.
- WRAP without AXI_RAM_WRAP_EN: same burst → bresp=SLVERR and the memory is unchanged.
- Errors: write at word index MEM_DEPTH → SLVERR. size=3 with STRB_W=4 → SLVERR. wlast asserted early on beat 1 of a len=3 burst → SLVERR after 4 beats. rst asserted mid read burst → rvalid drops asynchronously, and the next AR is serviced normally.
